// File: rtl/riskow_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riskow_pkg                                                   |
// | Description : Shared constants, types and helpers for the Riskow SoC:      |
// |               memory map, IO register offsets, bus width, decoded region   |
// |               enum, core state enum, RV32I opcodes, ALU and byte-strobe    |
// |               merge functions.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package riskow_pkg;

   localparam int BUS_W = 32;

   // Region bases and default depths (32-bit words).
   localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
   localparam logic [31:0] RAM_BASE   = 32'h0001_0000;
   localparam logic [31:0] EXCP_BASE  = 32'h0002_0000;
   localparam logic [31:0] PORTA_BASE = 32'hF000_0000;
   localparam logic [31:0] PORTB_BASE = 32'hF000_0010;
   localparam int ROM_WORDS_DEF  = 4096;
   localparam int RAM_WORDS_DEF  = 8192;
   localparam int EXCP_WORDS_DEF = 256;
   localparam int PORT_WORDS     = 4;

   // IO register byte offsets within a port.
   localparam logic [3:0] IO_OUT_OFF = 4'h0;
   localparam logic [3:0] IO_DIR_OFF = 4'h4;
   localparam logic [3:0] IO_IN_OFF  = 4'h8;

   typedef enum logic [2:0] {
      REG_ROM, REG_RAM, REG_EXCP, REG_PORTA, REG_PORTB, REG_NONE
   } region_e;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} cpu_state_e;

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LD    = 7'b0000011;
   localparam logic [6:0] OPC_ST    = 7'b0100011;
   localparam logic [6:0] OPC_OPI   = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   // Word-address window test; the subtraction keeps it free of constant compares.
   function automatic logic in_window(input logic [29:0] word, input logic [29:0] base,
                                      input logic [29:0] words);
      return (word - base) < words;
   endfunction

   function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   // alt selects SUB / SRA.
   function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (f3)
         3'b000:  r = alt ? a - b : a + b;
         3'b001:  r = a << b[4:0];
         3'b010:  r = {31'b0, $signed(a) < $signed(b)};
         3'b011:  r = {31'b0, a < b};
         3'b100:  r = a ^ b;
         3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/riskow_cpu.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riskow_cpu                                                   |
// | Description : Multi-cycle RV32I integer core (FETCH/EXEC/MEM). Resets to   |
// |               PC 0; an unrecognised opcode vectors to EXCP_BASE.           |
// | Ports       : clk, reset (sync, active-low); bus master o_addr/o_wdata/    |
// |               o_wstrb/o_we/o_valid, i_rdata/i_ready. o_valid is held      |
// |               until i_ready.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riskow_cpu
   import riskow_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] o_addr,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic        o_we,
   output logic        o_valid,
   input  logic [31:0] i_rdata,
   input  logic        i_ready
);
   cpu_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d;
   logic [31:0] regs_q [32];
   logic        rd_we;
   logic [31:0] rd_val;

   logic [6:0]  opc;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, mem_addr, ld_shift, ld_val;
   logic        alt, take;

   always_comb begin
      opc   = ir_q[6:0];
      rd    = ir_q[11:7];
      f3    = ir_q[14:12];
      rs1   = ir_q[19:15];
      rs2   = ir_q[24:20];
      imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
      imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      imm_b = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      imm_u = {ir_q[31:12], 12'b0};
      imm_j = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
      rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
      // ir[30] is an immediate bit for ADDI, so it only means SUB on register ops.
      alt      = ir_q[30] && ((opc == OPC_OP && f3 == 3'b000) || f3 == 3'b101);
      mem_addr = rs1_val + ((opc == OPC_ST) ? imm_s : imm_i);
      ld_shift = i_rdata >> {mem_addr[1:0], 3'b000};
      case (f3)
         3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_val = {24'b0, ld_shift[7:0]};
         3'b101:  ld_val = {16'b0, ld_shift[15:0]};
         default: ld_val = i_rdata;
      endcase
      case (f3)
         3'b000:  take = rs1_val == rs2_val;
         3'b001:  take = rs1_val != rs2_val;
         3'b100:  take = $signed(rs1_val) <  $signed(rs2_val);
         3'b101:  take = $signed(rs1_val) >= $signed(rs2_val);
         3'b110:  take = rs1_val <  rs2_val;
         3'b111:  take = rs1_val >= rs2_val;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      rd_we   = 1'b0;
      rd_val  = '0;
      o_valid = 1'b0;
      o_we    = 1'b0;
      o_addr  = pc_q;
      o_wdata = '0;
      o_wstrb = '0;
      case (state_q)
         S_FETCH: begin
            o_valid = 1'b1;
            if (i_ready) begin
               ir_d    = i_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_q + 32'd4;
            rd_we   = 1'b1;
            case (opc)
               OPC_LUI:   rd_val = imm_u;
               OPC_AUIPC: rd_val = pc_q + imm_u;
               OPC_JAL:   begin rd_val = pc_q + 32'd4; pc_d = pc_q + imm_j; end
               OPC_JALR:  begin rd_val = pc_q + 32'd4; pc_d = (rs1_val + imm_i) & ~32'd1; end
               OPC_OPI:   rd_val = alu_op(f3, alt, rs1_val, imm_i);
               OPC_OP:    rd_val = alu_op(f3, alt, rs1_val, rs2_val);
               OPC_BR: begin
                  rd_we = 1'b0;
                  if (take) pc_d = pc_q + imm_b;
               end
               OPC_LD, OPC_ST: begin
                  rd_we   = 1'b0;
                  pc_d    = pc_q;
                  state_d = S_MEM;
               end
               default: begin
                  rd_we = 1'b0;
                  pc_d  = EXCP_BASE;
               end
            endcase
         end
         default: begin
            o_valid = 1'b1;
            o_addr  = {mem_addr[31:2], 2'b00};
            if (opc == OPC_ST) begin
               o_we = 1'b1;
               case (f3[1:0])
                  2'b00:   begin o_wstrb = 4'b0001 << mem_addr[1:0]; o_wdata = {4{rs2_val[7:0]}}; end
                  2'b01:   begin o_wstrb = 4'b0011 << mem_addr[1:0]; o_wdata = {2{rs2_val[15:0]}}; end
                  default: begin o_wstrb = 4'b1111; o_wdata = rs2_val; end
               endcase
            end
            if (i_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = S_FETCH;
               rd_we   = (opc == OPC_LD);
               rd_val  = ld_val;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && rd_we && rd != 5'd0) regs_q[rd] <= rd_val;
   end

endmodule
`default_nettype wire

// File: rtl/riskow_io_port.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riskow_io_port                                               |
// | Description : 32-bit GPIO port with OUT (rw), DIR (rw, 1=output) and IN    |
// |               (ro) registers and per-pin tristate drivers. Only PINS low   |
// |               bits are bonded; unbonded IN bits read 0.                    |
// |               Macro RISKOW_IO_SYNC_EN: IN passes a two-flop synchronizer   |
// |               (2-cycle latency) instead of one registered sample.          |
// | Ports       : clk, reset (sync, active-low), i_we/i_sel/i_wdata/i_wstrb    |
// |               register write, o_rdata selected register, io_pin pads.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riskow_io_port
   import riskow_pkg::*;
#(
   parameter int PINS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_we,
   input  logic [1:0]       i_sel,
   input  logic [31:0]      i_wdata,
   input  logic [3:0]       i_wstrb,
   output logic [31:0]      o_rdata,
   inout  wire  [PINS-1:0]  io_pin
);
   localparam logic [1:0] SEL_OUT = IO_OUT_OFF[3:2];
   localparam logic [1:0] SEL_DIR = IO_DIR_OFF[3:2];
   localparam logic [1:0] SEL_IN  = IO_IN_OFF[3:2];

   logic [31:0]     out_q, out_d;
   // Kept as plain "direction" so benches can probe it by name.
   logic [31:0]     direction, direction_d;
   logic [PINS-1:0] in_q, in_d;

   always_comb begin
      out_d       = out_q;
      direction_d = direction;
      if (i_we && i_sel == SEL_OUT) out_d       = apply_strb(out_q, i_wdata, i_wstrb);
      if (i_we && i_sel == SEL_DIR) direction_d = apply_strb(direction, i_wdata, i_wstrb);
   end

`ifdef RISKOW_IO_SYNC_EN
   logic [PINS-1:0] meta_q;
   always_ff @(posedge clk) begin
      if (!reset) meta_q <= '0;
      else        meta_q <= io_pin;
   end
   always_comb in_d = meta_q;
`else
   always_comb in_d = io_pin;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q     <= '0;
         direction <= '0;
         in_q      <= '0;
      end else begin
         out_q     <= out_d;
         direction <= direction_d;
         in_q      <= in_d;
      end
   end

   always_comb begin
      case (i_sel)
         SEL_OUT: o_rdata = out_q;
         SEL_DIR: o_rdata = direction;
         SEL_IN:  o_rdata = 32'(in_q);
         default: o_rdata = '0;
      endcase
   end

   for (genvar i = 0; i < PINS; i++) begin : g_pin
      assign io_pin[i] = direction[i] ? out_q[i] : 1'bz;
   end

endmodule
`default_nettype wire

// File: rtl/riskow_top.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riskow_top                                                   |
// | Description : Riskow SoC top: riskow_cpu core, program ROM, exception ROM  |
// |               (EXCP), data RAM, address decoder and GPIO ports portA/portB.|
// |               Every bus access is answered one cycle after it is sampled;  |
// |               unmapped reads return 0 and unmapped writes are dropped.     |
// |               Optional macro RISKOW_IO_SYNC_EN (see riskow_io_port).       |
// | Ports       : clk; reset (sync, active-low); led = portB[0];               |
// |               lcd = portA[5:0].                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riskow_top
   import riskow_pkg::*;
#(
   parameter int ROM_WORDS  = ROM_WORDS_DEF,
   parameter int EXCP_WORDS = EXCP_WORDS_DEF,
   parameter int RAM_WORDS  = RAM_WORDS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire        led,
   inout  wire  [5:0] lcd
);
   localparam int ROM_AW  = $clog2(ROM_WORDS);
   localparam int EXCP_AW = $clog2(EXCP_WORDS);
   localparam int RAM_AW  = $clog2(RAM_WORDS);
   localparam logic [29:0] ROM_LO   = ROM_BASE[31:2];
   localparam logic [29:0] RAM_LO   = RAM_BASE[31:2];
   localparam logic [29:0] EXCP_LO  = EXCP_BASE[31:2];
   localparam logic [29:0] PORTA_LO = PORTA_BASE[31:2];
   localparam logic [29:0] PORTB_LO = PORTB_BASE[31:2];

   // Contents are not reset; benches preload them.
   reg [31:0] ROM  [0:ROM_WORDS-1];
   reg [31:0] EXCP [0:EXCP_WORDS-1];
   reg [31:0] RAM  [0:RAM_WORDS-1];

   logic [31:0] bus_addr, bus_wdata, rdata_q, rdata_d, porta_rdata, portb_rdata;
   logic [3:0]  bus_wstrb;
   logic        bus_we, bus_valid, ready_q, ready_d;
   logic        ram_we, porta_we, portb_we;
   logic [29:0] word;
   logic [RAM_AW-1:0] ram_idx;
   region_e     region;
   logic        unused_lsbs;

   assign word        = bus_addr[31:2];
   assign ram_idx     = RAM_AW'(word - RAM_LO);
   assign unused_lsbs = ^bus_addr[1:0];

   riskow_cpu u_cpu (
      .clk     (clk),
      .reset   (reset),
      .o_addr  (bus_addr),
      .o_wdata (bus_wdata),
      .o_wstrb (bus_wstrb),
      .o_we    (bus_we),
      .o_valid (bus_valid),
      .i_rdata (rdata_q),
      .i_ready (ready_q)
   );

   always_comb begin
      region = REG_NONE;
      if      (in_window(word, ROM_LO,   30'(ROM_WORDS)))  region = REG_ROM;
      else if (in_window(word, RAM_LO,   30'(RAM_WORDS)))  region = REG_RAM;
      else if (in_window(word, EXCP_LO,  30'(EXCP_WORDS))) region = REG_EXCP;
      else if (in_window(word, PORTA_LO, 30'(PORT_WORDS))) region = REG_PORTA;
      else if (in_window(word, PORTB_LO, 30'(PORT_WORDS))) region = REG_PORTB;
   end

   // A request is sampled when valid is seen without ready; the core holds
   // valid through the ready cycle, so masking with ready_q stops a repeat.
   always_comb begin
      ready_d  = 1'b0;
      rdata_d  = '0;
      ram_we   = 1'b0;
      porta_we = 1'b0;
      portb_we = 1'b0;
      if (bus_valid && !ready_q) begin
         ready_d = 1'b1;
         case (region)
            REG_ROM:   rdata_d = ROM[ROM_AW'(word - ROM_LO)];
            REG_EXCP:  rdata_d = EXCP[EXCP_AW'(word - EXCP_LO)];
            REG_RAM:   begin rdata_d = RAM[ram_idx]; ram_we = bus_we; end
            REG_PORTA: begin rdata_d = porta_rdata;  porta_we = bus_we; end
            REG_PORTB: begin rdata_d = portb_rdata;  portb_we = bus_we; end
            default:   rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && ram_we) RAM[ram_idx] <= apply_strb(RAM[ram_idx], bus_wdata, bus_wstrb);
   end

   riskow_io_port #(.PINS(6)) portA (
      .clk     (clk),
      .reset   (reset),
      .i_we    (porta_we),
      .i_sel   (word[1:0]),
      .i_wdata (bus_wdata),
      .i_wstrb (bus_wstrb),
      .o_rdata (porta_rdata),
      .io_pin  (lcd)
   );

   riskow_io_port #(.PINS(1)) portB (
      .clk     (clk),
      .reset   (reset),
      .i_we    (portb_we),
      .i_sel   (word[1:0]),
      .i_wdata (bus_wdata),
      .i_wstrb (bus_wstrb),
      .o_rdata (portb_rdata),
      .io_pin  (led)
   );

endmodule
`default_nettype wire

// File: tb/tb_riskow_top.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_riskow_top                                                |
// | Description : Self-checking bench for riskow_top. Small RV32I programs are |
// |               placed in ROM; expected load data is queued when a program  |
// |               is built and compared as each load completes on the bus.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_riskow_top;
   import riskow_pkg::*;

   localparam logic [31:0] HALT = 32'h0000_006F;   // jal x0, 0

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       lcd_en = 1'b0;
   logic [5:0] lcd_drv = 6'h00;
   wire        led;
   wire  [5:0] lcd;

   int total = 0;
   int bad   = 0;
   logic [31:0] prog[$];
   logic [31:0] exp_q[$];

   assign lcd = lcd_en ? lcd_drv : 6'bzzzzzz;
   pullup (led);
   pullup (lcd[0]);
   pullup (lcd[1]);
   pullup (lcd[2]);
   pullup (lcd[3]);
   pullup (lcd[4]);
   pullup (lcd[5]);

   always #5 clk = ~clk;

   riskow_top u_dut (
      .clk   (clk),
      .reset (reset),
      .led   (led),
      .lcd   (lcd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Instruction encoders.
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, 7'b0110111};
   endfunction
   function automatic logic [31:0] st(input logic [2:0] f3, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   // Scoreboard: every completed load is compared with the next queued value.
   always @(negedge clk) begin
      if (reset && u_dut.ready_q && u_dut.u_cpu.state_q == S_MEM && !u_dut.bus_we) begin
         logic [31:0] e;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
         check("sb_load", u_dut.rdata_q, e);
      end
   end

   task automatic start_prog();
      @(negedge clk);
      reset = 1'b0;
      foreach (prog[i]) u_dut.ROM[i] = prog[i];
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_halt(input string tag, input logic [31:0] pc);
      int n = 0;
      while (!(u_dut.u_cpu.state_q == S_EXEC && u_dut.u_cpu.pc_q == pc) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_halt_pc"}, u_dut.u_cpu.pc_q, pc);
      check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Program 1: portB DIR[0]=1 then OUT[0]=1 -> led driven high.
      prog = '{lui(1, 20'hF0000), addi(2, 0, 12'h001), st(3'b010, 2, 1, 12'h014),
               st(3'b010, 2, 1, 12'h010), HALT};
      foreach (prog[i]) u_dut.ROM[i] = prog[i];
      @(negedge clk);
      check("rst_dirA", u_dut.portA.direction, 32'h0);
      check("rst_dirB", u_dut.portB.direction, 32'h0);
      check("rst_led_hiz", {31'b0, led}, 32'h1);
      check("rst_lcd_hiz", {26'b0, lcd}, 32'h3F);
      check("rst_ready", {31'b0, u_dut.ready_q}, 32'h0);
      check("rst_rdata", u_dut.rdata_q, 32'h0);
      reset = 1'b1;
      wait_halt("p1", 32'h10);
      check("p1_dirB", u_dut.portB.direction, 32'h1);
      check("p1_led", {31'b0, led}, 32'h1);

      // Program 2: same setup then OUT[0]=0 -> led driven low.
      prog = '{lui(1, 20'hF0000), addi(2, 0, 12'h001), st(3'b010, 2, 1, 12'h014),
               st(3'b010, 2, 1, 12'h010), st(3'b010, 0, 1, 12'h010), HALT};
      start_prog();
      wait_halt("p2", 32'h14);
      check("p2_led", {31'b0, led}, 32'h0);

      // Program 3: RAM word/byte access, unmapped access, store to ROM.
      prog = '{lui(3, 20'h00010), lui(4, 20'hDEADC), addi(4, 4, 12'hEEF), st(3'b010, 4, 3, 12'h000),
               lw(5, 3, 12'h000), addi(6, 0, 12'h055), st(3'b000, 6, 3, 12'h001), lw(7, 3, 12'h000),
               lui(8, 20'h00080), st(3'b010, 4, 8, 12'h000), lw(9, 8, 12'h000), lw(10, 3, 12'h000),
               addi(11, 0, 12'h010), st(3'b010, 4, 11, 12'h000), lw(12, 11, 12'h000), HALT};
      exp_q = '{32'hDEADBEEF, 32'hDEAD55EF, 32'h0, 32'hDEAD55EF, lw(5, 3, 12'h000)};
      start_prog();
      wait_halt("p3", 32'h3C);
      check("p3_x5", u_dut.u_cpu.regs_q[5], 32'hDEADBEEF);
      check("p3_x7", u_dut.u_cpu.regs_q[7], 32'hDEAD55EF);
      check("p3_ram0", u_dut.RAM[0], 32'hDEAD55EF);

      // Reset during a store's sample cycle: nothing may be committed.
      prog = '{lui(3, 20'h00010), addi(4, 0, 12'h05A), st(3'b010, 4, 3, 12'h000), HALT};
      start_prog();
      begin
         int n = 0;
         while (!(u_dut.u_cpu.state_q == S_MEM && !u_dut.ready_q) && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      check("mid_state", 32'(u_dut.u_cpu.state_q), 32'(S_MEM));
      reset = 1'b0;
      @(negedge clk);
      check("mid_ready", {31'b0, u_dut.ready_q}, 32'h0);
      check("mid_ram0", u_dut.RAM[0], 32'hDEAD55EF);

      // Program 4: illegal opcode vectors into the EXCP ROM.
      prog = '{addi(15, 0, 12'h011), 32'hFFFF_FFFF, HALT};
      u_dut.EXCP[0] = addi(15, 15, 12'h066);
      u_dut.EXCP[1] = HALT;
      start_prog();
      wait_halt("p4", 32'h0002_0004);
      check("p4_x15", u_dut.u_cpu.regs_q[15], 32'h77);

      // Program 5: input sampling on both ports and a reserved port offset.
      lcd_drv = 6'h2A;
      lcd_en  = 1'b1;
      prog = '{lui(1, 20'hF0000), lw(2, 1, 12'h008), lw(3, 1, 12'h018), lw(4, 1, 12'h00C), HALT};
      exp_q = '{32'h2A, 32'h1, 32'h0};
      start_prog();
      wait_halt("p5", 32'h10);

      // Input latency after a pin change.
      lcd_drv = 6'h15;
      @(negedge clk);
`ifdef RISKOW_IO_SYNC_EN
      check("in_lat1", {26'b0, u_dut.portA.in_q}, 32'h2A);
`else
      check("in_lat1", {26'b0, u_dut.portA.in_q}, 32'h15);
`endif
      @(negedge clk);
      check("in_lat2", {26'b0, u_dut.portA.in_q}, 32'h15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
